// File: rtl/cluster_extractor_lite_pkg.sv
// Shared constants, state encoding and helpers for the cluster readout path.
package cluster_extractor_lite_pkg;

    // Ceiling log2 for sizing address and counter fields.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    localparam int NSTRIPS     = 768;
    localparam int ADRB        = clog2(NSTRIPS);
    // Also used by the cluster counter as its overflow threshold.
    localparam int MAXCLUSTERS = 8;
    localparam int CNTB        = clog2(MAXCLUSTERS + 1);

    // Lowest-set-bit search is split into 64-bit segments.
    localparam int SEG_W = 64;
    localparam int NSEG  = NSTRIPS / SEG_W;
    localparam int SEGB  = clog2(NSEG);
    localparam int BITB  = clog2(SEG_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cluster_extractor_lite_if.sv
// Load and readout bundle of the cluster extractor.
interface cluster_extractor_lite_if;
    import cluster_extractor_lite_pkg::*;

    logic [NSTRIPS-1:0] vpfs_i;
    logic               start_i;
    logic               busy_o;
    logic [ADRB-1:0]    adr_o;
    logic               valid_o;
    logic               ready_i;
    logic               last_o;
    logic [CNTB-1:0]    cnt_o;
    logic               overflow_o;
    logic               done_o;

    // Upstream/consumer side: drives the load and the ready.
    modport master (
        output vpfs_i, start_i, ready_i,
        input  busy_o, adr_o, valid_o, last_o, cnt_o, overflow_o, done_o
    );

    // Extractor side.
    modport slave (
        input  vpfs_i, start_i, ready_i,
        output busy_o, adr_o, valid_o, last_o, cnt_o, overflow_o, done_o
    );
endinterface

// File: rtl/cluster_extractor_lite_first_one_encoder.sv
// Combinational lowest-set-bit finder: per-segment flags, segment priority,
// then a 64-bit intra-segment encode. Also reports whether exactly one bit is set.
module first_one_encoder
    import cluster_extractor_lite_pkg::*;
(
    input  logic [NSTRIPS-1:0] vec,
    output logic [ADRB-1:0]    adr,
    output logic               any,
    output logic               single
);
    logic [NSEG-1:0]  seg_any_s;
    logic [NSEG-1:0]  seg_one_s;
    logic [SEGB-1:0]  sel_idx_s;
    logic             sel_found_s;
    logic             many_s;
    logic [SEG_W-1:0] sel_seg_s;
    logic [BITB-1:0]  bit_idx_s;
    logic             bit_found_s;

    // Per-segment occupancy and one-hot detection.
    always_comb begin
        seg_any_s = '0;
        seg_one_s = '0;
        for (int s = 0; s < NSEG; s++) begin
            seg_any_s[s] = |vec[s*SEG_W +: SEG_W];
            seg_one_s[s] = seg_any_s[s] &&
                ((vec[s*SEG_W +: SEG_W] & (vec[s*SEG_W +: SEG_W] - 64'd1)) == 64'd0);
        end
    end

    // Pick the lowest occupied segment; note whether any later one is occupied too.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        many_s      = 1'b0;
        for (int s = 0; s < NSEG; s++) begin
            if (seg_any_s[s] && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_idx_s   = SEGB'(s);
            end else begin
                many_s = many_s | seg_any_s[s];
            end
        end
    end

    assign sel_seg_s = vec[{sel_idx_s, 6'd0} +: SEG_W];

    // Lowest set bit inside the selected segment.
    always_comb begin
        bit_found_s = 1'b0;
        bit_idx_s   = '0;
        for (int b = 0; b < SEG_W; b++) begin
            if (sel_seg_s[b] && !bit_found_s) begin
                bit_found_s = 1'b1;
                bit_idx_s   = BITB'(b);
            end else begin
                bit_found_s = bit_found_s;
            end
        end
    end

    assign adr    = {sel_idx_s, bit_idx_s};
    assign any    = sel_found_s;
    assign single = sel_found_s & ~many_s & seg_one_s[sel_idx_s];

endmodule

// File: rtl/cluster_extractor_lite.sv
// Sequential VPF readout: latches a flag vector on start and emits the address
// of each set flag, lowest first, one per accepted beat, up to MAXCLUSTERS.
module cluster_extractor_lite
    import cluster_extractor_lite_pkg::*;
(
    input  logic                     clock4x,
    input  logic                     reset_n,
    cluster_extractor_lite_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNTB-1:0]    CNT_ONE  = {{(CNTB-1){1'b0}}, 1'b1};
    localparam logic [CNTB-1:0]    CNT_LAST = CNTB'(MAXCLUSTERS - 1);
    localparam logic [NSTRIPS-1:0] BIT0     = {{(NSTRIPS-1){1'b0}}, 1'b1};

    logic [1:0]         state_r, state_s;
    logic [NSTRIPS-1:0] work_r, work_s;
    logic [CNTB-1:0]    cnt_r, cnt_s;
    logic               ovf_r, ovf_s;

    logic [ADRB-1:0]    enc_adr_s;
    logic               enc_any_s;
    logic               enc_single_s;
    logic               valid_s;
    logic               accept_s;
    logic [NSTRIPS-1:0] clr_mask_s;

    first_one_encoder u_enc (
        .vec    (work_r),
        .adr    (enc_adr_s),
        .any    (enc_any_s),
        .single (enc_single_s)
    );

    assign valid_s    = (state_r == ST_SCAN) & enc_any_s;
    assign accept_s   = valid_s & bus.ready_i;
    assign clr_mask_s = BIT0 << enc_adr_s;

    // Next-state, working-register clear and beat counting.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        cnt_s   = cnt_r;
        ovf_s   = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    work_s  = bus.vpfs_i;
                    cnt_s   = '0;
                    ovf_s   = 1'b0;
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!enc_any_s) begin
                    state_s = ST_DONE;
                end else if (accept_s) begin
                    work_s = work_r & ~clr_mask_s;
                    cnt_s  = cnt_r + CNT_ONE;
                    if (enc_single_s) begin
                        // The register empties with this beat.
                        state_s = ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Limit reached with flags left: drop the rest.
                        state_s = ST_DONE;
                        ovf_s   = 1'b1;
                        work_s  = '0;
                    end else begin
                        state_s = ST_SCAN;
                    end
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                work_s  = '0;
            end
            default: begin
                state_s = ST_IDLE;
                work_s  = '0;
            end
        endcase
    end

    // State, working register, counter and overflow flag.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            work_r  <= '0;
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
        end
    end

    assign bus.busy_o     = (state_r != ST_IDLE);
    assign bus.valid_o    = valid_s;
    assign bus.adr_o      = valid_s ? enc_adr_s : {ADRB{1'b0}};
    assign bus.last_o     = valid_s & (enc_single_s | (cnt_r == CNT_LAST));
    assign bus.cnt_o      = cnt_r;
    assign bus.overflow_o = ovf_r;
    assign bus.done_o     = (state_r == ST_DONE);

endmodule

// File: tb/tb_cluster_extractor_lite.sv
// Directed, table-driven bench for cluster_extractor_lite.
module tb_cluster_extractor_lite;
    import cluster_extractor_lite_pkg::*;

    typedef logic [0:9][ADRB-1:0] adr_list_t;
    typedef int int_list_t [10];

    typedef struct packed {
        adr_list_t  flg;       // set flags, ascending
        logic [3:0] nflg;
        adr_list_t  exp;       // expected addresses in emission order
        logic [3:0] nexp;
        logic       ovf;
        logic       toggle;    // ready alternates 1/0 instead of held high
        logic       glitch;    // pulse start during SCAN and DONE
        logic [7:0] done_cyc;  // expected done cycle after start edge; 0 = unchecked
    } vec_t;

    logic clock4x = 1'b0;
    logic reset_n = 1'b0;
    int   passed  = 0;
    int   total   = 0;
    vec_t vecs [7];

    always #5 clock4x = ~clock4x;

    cluster_extractor_lite_if bus ();

    cluster_extractor_lite dut (
        .clock4x (clock4x),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic adr_list_t pack10(input int_list_t a);
        adr_list_t r;
        for (int i = 0; i < 10; i++) r[i] = ADRB'(a[i]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            passed = passed + 1;
    endtask

    task automatic step();
        @(posedge clock4x);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  32'(bus.busy_o),     32'd0);
        chk({tag, "_valid"}, 32'(bus.valid_o),    32'd0);
        chk({tag, "_adr"},   32'(bus.adr_o),      32'd0);
        chk({tag, "_last"},  32'(bus.last_o),     32'd0);
        chk({tag, "_cnt"},   32'(bus.cnt_o),      32'd0);
        chk({tag, "_ovf"},   32'(bus.overflow_o), 32'd0);
        chk({tag, "_done"},  32'(bus.done_o),     32'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t               v;
        logic [NSTRIPS-1:0] vp;
        int                 beat;
        bit                 got_done;
        v        = vecs[i];
        beat     = 0;
        got_done = 1'b0;
        vp       = '0;
        for (int j = 0; j < int'(v.nflg); j++) vp[v.flg[j]] = 1'b1;
        bus.vpfs_i  = vp;
        bus.start_i = 1'b1;
        bus.ready_i = 1'b0;
        step();
        bus.start_i = 1'b0;
        bus.vpfs_i  = '0;
        for (int cyc = 1; cyc < 40 && !got_done; cyc++) begin
            if (bus.valid_o) begin
                if (beat < int'(v.nexp)) begin
                    chk($sformatf("v%0d_adr%0d", i, beat), 32'(bus.adr_o), 32'(v.exp[beat]));
                    chk($sformatf("v%0d_last%0d", i, beat), 32'(bus.last_o),
                        32'(beat == int'(v.nexp) - 1));
                end else begin
                    chk($sformatf("v%0d_extra_beat", i), 32'(beat), 32'(v.nexp));
                end
            end else begin
                chk($sformatf("v%0d_idle_adr_c%0d", i, cyc), 32'({bus.adr_o, bus.last_o}), 32'd0);
            end
            if (bus.done_o) begin
                got_done = 1'b1;
                chk($sformatf("v%0d_beats", i), 32'(beat), 32'(v.nexp));
                chk($sformatf("v%0d_cnt", i), 32'(bus.cnt_o), 32'(v.nexp));
                chk($sformatf("v%0d_ovf", i), 32'(bus.overflow_o), 32'(v.ovf));
                if (v.done_cyc != 8'd0)
                    chk($sformatf("v%0d_done_cyc", i), 32'(cyc), 32'(v.done_cyc));
            end
            bus.ready_i = v.toggle ? ((cyc % 2) == 1) : 1'b1;
            if (v.glitch && (cyc == 2 || bus.done_o)) begin
                bus.start_i = 1'b1;
                bus.vpfs_i  = '1;
            end else begin
                bus.start_i = 1'b0;
                bus.vpfs_i  = '0;
            end
            if (bus.valid_o && bus.ready_i) beat = beat + 1;
            step();
        end
        bus.start_i = 1'b0;
        bus.vpfs_i  = '0;
        bus.ready_i = 1'b0;
        if (!got_done) chk($sformatf("v%0d_timeout", i), 32'd0, 32'd1);
        chk($sformatf("v%0d_back_idle", i), 32'({bus.busy_o, bus.done_o, bus.valid_o}), 32'd0);
        chk($sformatf("v%0d_cnt_hold", i), 32'(bus.cnt_o), 32'(v.nexp));
        step();
    endtask

    initial begin
        vecs[0] = '{flg: '0, nflg: 4'd0, exp: '0, nexp: 4'd0, ovf: 1'b0,
                    toggle: 1'b0, glitch: 1'b0, done_cyc: 8'd2};
        vecs[1] = '{flg: pack10('{5, 100, 767, 0, 0, 0, 0, 0, 0, 0}), nflg: 4'd3,
                    exp: pack10('{5, 100, 767, 0, 0, 0, 0, 0, 0, 0}), nexp: 4'd3, ovf: 1'b0,
                    toggle: 1'b0, glitch: 1'b0, done_cyc: 8'd4};
        vecs[2] = '{flg: pack10('{0, 63, 64, 0, 0, 0, 0, 0, 0, 0}), nflg: 4'd3,
                    exp: pack10('{0, 63, 64, 0, 0, 0, 0, 0, 0, 0}), nexp: 4'd3, ovf: 1'b0,
                    toggle: 1'b1, glitch: 1'b0, done_cyc: 8'd0};
        vecs[3] = '{flg: pack10('{10, 20, 30, 40, 50, 60, 70, 80, 90, 100}), nflg: 4'd10,
                    exp: pack10('{10, 20, 30, 40, 50, 60, 70, 80, 0, 0}), nexp: 4'd8, ovf: 1'b1,
                    toggle: 1'b0, glitch: 1'b0, done_cyc: 8'd9};
        vecs[4] = '{flg: pack10('{1, 2, 3, 200, 400, 600, 700, 766, 0, 0}), nflg: 4'd8,
                    exp: pack10('{1, 2, 3, 200, 400, 600, 700, 766, 0, 0}), nexp: 4'd8, ovf: 1'b0,
                    toggle: 1'b0, glitch: 1'b0, done_cyc: 8'd9};
        vecs[5] = '{flg: pack10('{700, 701, 702, 703, 704, 705, 706, 707, 708, 0}), nflg: 4'd9,
                    exp: pack10('{700, 701, 702, 703, 704, 705, 706, 707, 0, 0}), nexp: 4'd8,
                    ovf: 1'b1, toggle: 1'b0, glitch: 1'b0, done_cyc: 8'd9};
        vecs[6] = '{flg: pack10('{5, 100, 767, 0, 0, 0, 0, 0, 0, 0}), nflg: 4'd3,
                    exp: pack10('{5, 100, 767, 0, 0, 0, 0, 0, 0, 0}), nexp: 4'd3, ovf: 1'b0,
                    toggle: 1'b0, glitch: 1'b1, done_cyc: 8'd4};

        bus.vpfs_i  = '0;
        bus.start_i = 1'b0;
        bus.ready_i = 1'b0;
        #12;
        chk_reset_vals("por");
        reset_n = 1'b1;
        step();
        chk_reset_vals("post_rel");

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset while a beat is pending: everything clears at once.
        bus.vpfs_i  = '0;
        bus.vpfs_i[5]   = 1'b1;
        bus.vpfs_i[100] = 1'b1;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.vpfs_i  = '0;
        chk("rst_pre_valid", 32'(bus.valid_o), 32'd1);
        chk("rst_pre_adr",   32'(bus.adr_o),   32'd5);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        reset_n = 1'b1;
        bus.ready_i = 1'b1;
        step();
        chk_reset_vals("rst_after1");
        step();
        chk_reset_vals("rst_after2");
        bus.ready_i = 1'b0;
        run_vec(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cluster_extractor_lite.md
# cluster_extractor_lite

Sequential readout companion to the cluster counter. It latches a 768-bit valid-pattern-flag (VPF) vector on a start strobe and emits the strip address of each set flag, lowest address first, one per accepted valid/ready beat. It stops after `MAXCLUSTERS` addresses and flags overflow when further flags remain. It sits between cluster finding and the packer, in the `clock4x` domain.

## Interface
- `NSTRIPS`, 768, width of the VPF vector; must be a multiple of 64.
- `ADRB`, 10, address width; `clog2(NSTRIPS)`.
- `MAXCLUSTERS`, 8, maximum number of addresses emitted per load.
- `CNTB`, 4, width of `cnt_o`; `clog2(MAXCLUSTERS+1)`.

Ports:
- `clock4x`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vpfs_i`  in  NSTRIPS  VPF vector; sampled only on an accepted start.
- `start_i`  in  1  load strobe; honoured only in IDLE.
- `busy_o`  out  1  high whenever state is not IDLE.
- `adr_o`  out  ADRB  address of the lowest remaining set flag; zero when `valid_o` is low.
- `valid_o`  out  1  `adr_o` is valid.
- `ready_i`  in  1  consumer accepts the beat when `valid_o & ready_i`.
- `last_o`  out  1  qualifies the final beat of the current load.
- `cnt_o`  out  CNTB  number of beats accepted since the last start.
- `overflow_o`  out  1  `MAXCLUSTERS` beats were sent and flags remained.
- `done_o`  out  1  one-cycle pulse at the end of a readout.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE**
  - `start_i=1`: latch `vpfs_i` into the working register, clear the beat counter, clear `overflow_o`, go to SCAN.
  - `start_i=0`: remain in IDLE.
- **SCAN, working register zero**: `valid_o=0`; go to DONE.
- **SCAN, working register nonzero**
  - `valid_o=1` and `adr_o` = index of the lowest set bit.
  - On accept: clear that bit and increment the counter.
  - Go to DONE if the post-clear register is zero, or if the counter reaches `MAXCLUSTERS`.
  - In the second case, set `overflow_o` if the post-clear register is nonzero; the remaining bits are discarded.
- **`last_o`**: `valid_o & ((working register has exactly one bit set) | (counter == MAXCLUSTERS-1))`.
- **DONE**: `done_o=1` for exactly one cycle, then go to IDLE.
- `cnt_o` and `overflow_o` hold their values until the next accepted start.
- `start_i` in SCAN or DONE is ignored and not queued.
- `ready_i` while `valid_o=0` has no effect. `valid_o`, once high, stays high with `adr_o` stable until accepted.
- The counter saturates by construction and never wraps.

## Timing
- Reset values: state IDLE, working register 0, `busy_o=0`, `valid_o=0`, `adr_o=0`, `last_o=0`, `cnt_o=0`, `overflow_o=0`, `done_o=0`.
- `reset_n` low mid-SCAN aborts immediately: the in-flight beat is dropped and nothing is emitted after release.
- With `start_i` sampled at edge N, `valid_o` first rises in cycle N+1.
- With `ready_i` held high and k set flags (k ≤ MAXCLUSTERS), addresses appear in cycles N+1 … N+k, `done_o` in N+k+1, and the block is back in IDLE at N+k+2.
- Empty vector: `done_o` in cycle N+2.
- Throughput: one address per cycle under continuous ready.
- All outputs derive from registered state only. There is no combinational path from `vpfs_i`, `start_i` or `ready_i` to any output.

## Structure
- Shared package holds:
  - `NSTRIPS`, `ADRB`, and the `MAXCLUSTERS` default of 8, which is shared with the counter's overflow threshold;
  - the state enum (`IDLE`, `SCAN`, `DONE`);
  - a `clog2` helper.
- Sub-module `first_one_encoder`: combinational lowest-set-bit finder. It is hierarchical: 12 segments of 64 bits, a 12-way segment priority stage, then a 64-bit intra-segment encode. Outputs:
  - `adr`;
  - `any`;
  - `single` (exactly one bit set), which drives `last_o`.
- The top level holds the FSM, the working register and its clear-by-address logic, and the counter.

## Test plan
- All-zero vector, start at cycle 0 → no `valid_o`; `done_o` in cycle 2; `cnt_o=0`; `overflow_o=0`.
- Flags {5, 100, 767}, ready high → addresses 5, 100, 767 in cycles 1–3; `last_o` only with 767; `done_o` in cycle 4; `cnt_o=3`.
- Flags {0, 63, 64}, ready toggling 1/0 → each address held stable while ready is low; order 0, 63, 64; no beat duplicated or lost.
- Flags {10, 20, …, 100} (10 flags), ready high → 8 addresses 10 … 80; `last_o` with 80; `cnt_o=8`; `overflow_o=1`.
- Exactly 8 flags → `cnt_o=8`, `overflow_o=0`.
- `start_i` pulsed during SCAN with a different vector → ignored; the original readout completes unchanged.
- `reset_n` asserted while `valid_o` is high → all outputs are at reset values in the same cycle; a subsequent start behaves normally.
